// File: rtl/trng_bit_collector_pkg.sv
// Shared constants and the sample-period clamp for the TRNG bit collector.
// Package name is trng_collector_pkg; imported by the collector, its interface and the corrector.
package trng_collector_pkg;

    localparam int SAMPLE_CNT_MIN = 17;
    localparam int WORD_W         = 16;
    localparam int RWC_W          = 5;

    // The floor keeps each word on data_in16bit for the consumer's 16-cycle serial scan.
    function automatic logic [31:0] eff_period(input logic [31:0] sample_cnt);
        return (sample_cnt < 32'(SAMPLE_CNT_MIN)) ? 32'(SAMPLE_CNT_MIN) : sample_cnt;
    endfunction

endpackage

// File: rtl/trng_bit_collector_if.sv
// Word hand-off between the bit collector and the autocorrelation/CRNGT chain.
interface trng_bit_collector_if;
    import trng_collector_pkg::*;

    logic [WORD_W-1:0] data_in16bit;
    logic              valid_16bit;
    logic              accum_enough_bits;
    logic [RWC_W-1:0]  round_word_cnt;
    logic              autocorr_finish_curr;

    modport master (
        output data_in16bit, valid_16bit, accum_enough_bits, round_word_cnt,
        input  autocorr_finish_curr
    );

    modport slave (
        input  data_in16bit, valid_16bit, accum_enough_bits, round_word_cnt,
        output autocorr_finish_curr
    );

endinterface

// File: rtl/trng_vn_corrector.sv
// Von Neumann corrector: pairs samples, 01 -> 0, 10 -> 1, 00/11 dropped.
// Only built when TRNG_VN_CORRECTOR_EN is defined.
`ifdef TRNG_VN_CORRECTOR_EN
module trng_vn_corrector (
    input  logic rng_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic smp_stb,
    input  logic smp_bit,
    output logic acc_stb,
    output logic acc_bit
);

    logic have_q;
    logic first_q;

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            have_q  <= 1'b0;
            first_q <= 1'b0;
        end else if (clr) begin
            have_q  <= 1'b0;
        end else if (smp_stb) begin
            have_q <= !have_q;
            if (!have_q) first_q <= smp_bit;
        end
    end

    assign acc_stb = smp_stb && !clr && have_q && (first_q != smp_bit);
    assign acc_bit = first_q;

endmodule
`endif

// File: rtl/trng_bit_collector.sv
// Samples the synchronized ring-oscillator bit into 16-bit words and tracks autocorrelation rounds.
// Define TRNG_VN_CORRECTOR_EN to insert the von Neumann corrector ahead of the shift register.
module trng_bit_collector
    import trng_collector_pkg::*;
#(
    parameter int ROUND_WORDS  = 12,
    parameter int SAMPLE_CNT_W = 16
) (
    input  logic                    rng_clk,
    input  logic                    rst_n,
    input  logic                    rnd_src_en,
    input  logic                    rst_trng_logic,
    input  logic                    raw_bit,
    input  logic [SAMPLE_CNT_W-1:0] sample_cnt,
    input  logic                    auto_correlate_bypass,
    trng_bit_collector_if.master    col
);

    logic [SAMPLE_CNT_W-1:0] period_m1;
    logic [SAMPLE_CNT_W-1:0] cnt_q, cnt_cur, cnt_d;
    logic                    run_q;
    logic                    clr_src;
    logic                    stall;
    logic                    smp_stb;
    logic                    acc_stb;
    logic                    acc_bit;
    logic [WORD_W-2:0]       sh_q;
    logic [3:0]              fill_q;
    logic [WORD_W-1:0]       data_q;
    logic                    valid_q;
    logic                    accum_q;
    logic [RWC_W-1:0]        rwc_q;
    logic [RWC_W-1:0]        rwc_base;
    logic [RWC_W-1:0]        rwc_inc;
    logic                    round_full;
    logic                    word_done;

    assign period_m1 = SAMPLE_CNT_W'(eff_period(32'(sample_cnt)) - 32'd1);
    assign clr_src   = !rnd_src_en || rst_trng_logic;
    assign stall     = accum_q;

    // run_q low means the counter has not started yet, so it reads as freshly loaded.
    assign cnt_cur = run_q ? cnt_q : period_m1;
    assign smp_stb = !clr_src && !stall && (cnt_cur == '0);

    always_comb begin
        cnt_d = cnt_cur;
        if (clr_src || smp_stb) begin
            cnt_d = period_m1;
        end else if (!stall) begin
            cnt_d = cnt_cur - SAMPLE_CNT_W'(1);
        end
    end

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= !clr_src;
            cnt_q <= cnt_d;
        end
    end

`ifdef TRNG_VN_CORRECTOR_EN
    trng_vn_corrector u_vn (
        .rng_clk (rng_clk),
        .rst_n   (rst_n),
        .clr     (clr_src || stall),
        .smp_stb (smp_stb),
        .smp_bit (raw_bit),
        .acc_stb (acc_stb),
        .acc_bit (acc_bit)
    );
`else
    assign acc_stb = smp_stb;
    assign acc_bit = raw_bit;
`endif

    // The 16th bit goes straight into the output word, so only 15 bits are held here.
    assign word_done = acc_stb && (fill_q == 4'hF);

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= word_done;
            if (clr_src) begin
                sh_q   <= '0;
                fill_q <= '0;
            end else if (acc_stb) begin
                sh_q   <= {acc_bit, sh_q[WORD_W-2:1]};
                fill_q <= fill_q + 4'd1;
            end
            if (rst_trng_logic) begin
                data_q <= '0;
            end else if (word_done) begin
                data_q <= {acc_bit, sh_q};
            end
        end
    end

    assign rwc_base   = col.autocorr_finish_curr ? '0 : rwc_q;
    assign rwc_inc    = rwc_base + RWC_W'(1);
    assign round_full = (rwc_inc == RWC_W'(ROUND_WORDS));

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            rwc_q   <= '0;
            accum_q <= 1'b0;
        end else if (rst_trng_logic) begin
            rwc_q   <= '0;
            accum_q <= 1'b0;
        end else if (word_done) begin
            rwc_q   <= (auto_correlate_bypass && round_full) ? '0 : rwc_inc;
            accum_q <= !auto_correlate_bypass && round_full;
        end else if (col.autocorr_finish_curr) begin
            rwc_q   <= '0;
            accum_q <= 1'b0;
        end
    end

    assign col.data_in16bit      = data_q;
    assign col.valid_16bit       = valid_q;
    assign col.accum_enough_bits = accum_q;
    assign col.round_word_cnt    = rwc_q;

endmodule
